// File: rtl/acc_compute_sequencer.sv
// Compute-pass sequencer between the command controller's toggle strobes and the MAC array / output buffer.
// Optional busy-cycle performance counter is enabled by defining ACC_SEQ_PERF_CNT_EN.
module acc_compute_sequencer #(
    parameter int M        = 16,
    parameter int PIPE_LAT = 4,
    parameter int ADDR_W   = $clog2(M)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              isNewDin,
    input  logic              isNewWtin,
    output logic              wt_load,
    output logic              in_valid,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic [ADDR_W:0]   row_count,
    output logic              err_no_wt,
    output logic              err_overrun,
    output logic [15:0]       perf_busy_cycles
);

    typedef enum logic [2:0] {IDLE, LOAD_WT, ISSUE, WAIT, WRITE} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(M - 1);
    localparam logic [ADDR_W:0]   ROW_MAX   = (ADDR_W + 1)'(M);
    localparam logic [7:0]        LAT       = 8'(PIPE_LAT);

    state_e              state_q, state_d;
    logic                din_hist_q, din_hist_d;
    logic                wt_hist_q, wt_hist_d;
    logic                pend_in_q, pend_in_d;
    logic                pend_wt_q, pend_wt_d;
    logic                wt_valid_q, wt_valid_d;
    logic                err_no_wt_q, err_no_wt_d;
    logic                err_overrun_q, err_overrun_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [ADDR_W:0]     row_count_q, row_count_d;
    logic                in_tgl, wt_tgl;
    logic                pend_in_now, pend_wt_now;

    // State register
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign in_tgl      = isNewDin ^ din_hist_q;
    assign wt_tgl      = isNewWtin ^ wt_hist_q;
    assign pend_in_now = pend_in_q | in_tgl;
    assign pend_wt_now = pend_wt_q | wt_tgl;

    // Next-state and datapath next values
    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        din_hist_d    = isNewDin;
        wt_hist_d     = isNewWtin;
        pend_in_d     = pend_in_now;
        pend_wt_d     = pend_wt_now;
        wt_valid_d    = wt_valid_q;
        err_no_wt_d   = err_no_wt_q;
        err_overrun_d = err_overrun_q;
        cnt_d         = cnt_q;
        out_addr_d    = out_addr_q;
        row_count_d   = row_count_q;

        // A pending input being consumed in ISSUE makes room for a new toggle.
        if (in_tgl && pend_in_q && (state_q != ISSUE)) err_overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pend_wt_now) begin
                    state_d = LOAD_WT;
                end else if (pend_in_now && wt_valid_q) begin
                    state_d = ISSUE;
                end else if (pend_in_now) begin
                    pend_in_d   = 1'b0;
                    err_no_wt_d = 1'b1;
                end
            end
            LOAD_WT: begin
                pend_wt_d  = wt_tgl;
                wt_valid_d = 1'b1;
                state_d    = IDLE;
            end
            ISSUE: begin
                pend_in_d = in_tgl;
                cnt_d     = LAT;
                state_d   = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = WRITE;
            end
            WRITE: begin
                out_addr_d = (out_addr_q == LAST_ADDR) ? '0 : out_addr_q + 1'b1;
                if (row_count_q != ROW_MAX) row_count_d = row_count_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers; reset returns toggle history to the controller's reset value.
    always_ff @(posedge clock) begin
        if (reset) begin
            din_hist_q    <= 1'b0;
            wt_hist_q     <= 1'b0;
            pend_in_q     <= 1'b0;
            pend_wt_q     <= 1'b0;
            wt_valid_q    <= 1'b0;
            err_no_wt_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            cnt_q         <= '0;
            out_addr_q    <= '0;
            row_count_q   <= '0;
        end else begin
            din_hist_q    <= din_hist_d;
            wt_hist_q     <= wt_hist_d;
            pend_in_q     <= pend_in_d;
            pend_wt_q     <= pend_wt_d;
            wt_valid_q    <= wt_valid_d;
            err_no_wt_q   <= err_no_wt_d;
            err_overrun_q <= err_overrun_d;
            cnt_q         <= cnt_d;
            out_addr_q    <= out_addr_d;
            row_count_q   <= row_count_d;
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy     = (state_q != IDLE);
        wt_load  = (state_q == LOAD_WT);
        in_valid = (state_q == ISSUE);
        out_we   = (state_q == WRITE);
    end

    assign out_addr    = out_addr_q;
    assign row_count   = row_count_q;
    assign err_no_wt   = err_no_wt_q;
    assign err_overrun = err_overrun_q;

`ifdef ACC_SEQ_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (busy && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_busy_cycles = perf_q;
`else
    assign perf_busy_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_acc_compute_sequencer.sv
// Directed testbench for acc_compute_sequencer (M=16, PIPE_LAT=4); expected values are hand-derived.
module tb_acc_compute_sequencer;

    localparam int M        = 16;
    localparam int PIPE_LAT = 4;
    localparam int ADDR_W   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              isNewDin = 1'b0;
    logic              isNewWtin = 1'b0;
    logic              wt_load, in_valid, out_we, busy;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W:0]   row_count;
    logic              err_no_wt, err_overrun;
    logic [15:0]       perf_busy_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wt = 0, n_iv = 0, n_we = 0;

    acc_compute_sequencer #(.M(M), .PIPE_LAT(PIPE_LAT)) dut (
        .clock            (clock),
        .reset            (reset),
        .isNewDin         (isNewDin),
        .isNewWtin        (isNewWtin),
        .wt_load          (wt_load),
        .in_valid         (in_valid),
        .out_we           (out_we),
        .out_addr         (out_addr),
        .busy             (busy),
        .row_count        (row_count),
        .err_no_wt        (err_no_wt),
        .err_overrun      (err_overrun),
        .perf_busy_cycles (perf_busy_cycles)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled away from the active edge
    always @(negedge clock) begin
        if (wt_load)  n_wt++;
        if (in_valid) n_iv++;
        if (out_we)   n_we++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        isNewDin  = 1'b0;
        isNewWtin = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // Waits up to a bounded number of cycles for out_we; a timeout counts as a failure.
    task automatic wait_we(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (out_we) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: out_we never rose within 12 cycles", name);
        end
    endtask

    task automatic load_weights();
        isNewWtin = ~isNewWtin;
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        n_tests++;
        if ({wt_load, in_valid, out_we, busy, err_no_wt, err_overrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 000000",
                     {wt_load, in_valid, out_we, busy, err_no_wt, err_overrun});
        end
        n_tests++;
        if ({out_addr, row_count, perf_busy_cycles} !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: addr %0d rows %0d perf %0d required all 0",
                     out_addr, row_count, perf_busy_cycles);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_pass();
        int wt0, iv0, we0;
        do_reset();
        wt0 = n_wt; iv0 = n_iv; we0 = n_we;
        isNewWtin = 1'b1;
        step(1);
        n_tests++;
        if (wt_load !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_wt_load: wt_load %b busy %b required 1 1", wt_load, busy);
        end
        step(9);
        isNewDin = 1'b1;
        step(1);
        n_tests++;
        if (in_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_in_valid: got %b required 1", in_valid);
        end
        for (int k = 1; k <= PIPE_LAT + 1; k++) begin
            step(1);
            n_tests++;
            if (out_we !== (k == PIPE_LAT + 1) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_we_timing: cycle %0d after in_valid out_we %b busy %b required %b 1",
                         k, out_we, busy, (k == PIPE_LAT + 1));
            end
        end
        n_tests++;
        if (out_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_we_addr: got %0d required 0", out_addr);
        end
        step(1);
        n_tests++;
        if (out_addr !== 4'd1 || row_count !== 5'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_write: addr %0d rows %0d busy %b required 1 1 0",
                     out_addr, row_count, busy);
        end
        n_tests++;
        if (n_wt - wt0 != 1 || n_iv - iv0 != 1 || n_we - we0 != 1) begin
            n_fail++;
            $display("FAIL basic_pulse_counts: wt %0d iv %0d we %0d required 1 1 1",
                     n_wt - wt0, n_iv - iv0, n_we - we0);
        end
    endtask

    task automatic test_no_weights();
        int iv0;
        do_reset();
        iv0 = n_iv;
        isNewDin = 1'b1;
        step(1);
        n_tests++;
        if (err_no_wt !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_wt_flag: err_no_wt %b busy %b required 1 0", err_no_wt, busy);
        end
        step(8);
        n_tests++;
        if (n_iv != iv0 || busy !== 1'b0 || err_no_wt !== 1'b1) begin
            n_fail++;
            $display("FAIL no_wt_quiet: in_valid pulses %0d busy %b err %b required 0 0 1",
                     n_iv - iv0, busy, err_no_wt);
        end
    endtask

    task automatic test_both_same_cycle();
        do_reset();
        isNewDin  = 1'b1;
        isNewWtin = 1'b1;
        step(1);
        n_tests++;
        if (wt_load !== 1'b1 || in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL both_first: wt_load %b in_valid %b required 1 0", wt_load, in_valid);
        end
        step(1);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL both_gap: busy %b required 0", busy);
        end
        step(1);
        n_tests++;
        if (in_valid !== 1'b1 || err_no_wt !== 1'b0) begin
            n_fail++;
            $display("FAIL both_issue: in_valid %b err_no_wt %b required 1 0", in_valid, err_no_wt);
        end
        step(PIPE_LAT + 2);
        n_tests++;
        if (row_count !== 5'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL both_done: rows %0d busy %b required 1 0", row_count, busy);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int exp_rows;
        do_reset();
        load_weights();
        for (int p = 0; p < M + 1; p++) begin
            isNewDin = ~isNewDin;
            wait_we("wrap_wait", ok);
            if (!ok) return;
            n_tests++;
            if (out_addr !== 4'(p % M)) begin
                n_fail++;
                $display("FAIL wrap_addr: pass %0d addr %0d required %0d", p, out_addr, p % M);
            end
            step(1);
            exp_rows = (p + 1 > M) ? M : p + 1;
            n_tests++;
            if (row_count !== 5'(exp_rows)) begin
                n_fail++;
                $display("FAIL wrap_rows: pass %0d rows %0d required %0d", p, row_count, exp_rows);
            end
        end
        n_tests++;
        if (out_addr !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_final_addr: got %0d required 1", out_addr);
        end
    endtask

    task automatic test_overrun();
        int iv0, we0;
        do_reset();
        load_weights();
        iv0 = n_iv; we0 = n_we;
        isNewDin = ~isNewDin;
        step(2);
        isNewDin = ~isNewDin;
        step(1);
        n_tests++;
        if (err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_first: err_overrun %b required 0", err_overrun);
        end
        isNewDin = ~isNewDin;
        step(1);
        n_tests++;
        if (err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_second: err_overrun %b required 1", err_overrun);
        end
        step(20);
        n_tests++;
        if (n_iv - iv0 != 2 || n_we - we0 != 2 || err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_passes: in_valid %0d out_we %0d err %b required 2 2 1",
                     n_iv - iv0, n_we - we0, err_overrun);
        end
    endtask

    task automatic test_reset_mid_pass();
        int we0;
        bit ok;
        int exp_perf;
        do_reset();
        load_weights();
        isNewDin = ~isNewDin;
        step(3);
        we0       = n_we;
        reset     = 1'b1;
        isNewDin  = 1'b0;
        isNewWtin = 1'b0;
        step(1);
        n_tests++;
        if ({wt_load, in_valid, out_we, busy, out_addr, row_count, perf_busy_cycles} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: we %b busy %b addr %0d rows %0d perf %0d required all 0",
                     out_we, busy, out_addr, row_count, perf_busy_cycles);
        end
        reset = 1'b0;
        step(8);
        n_tests++;
        if (n_we != we0) begin
            n_fail++;
            $display("FAIL midreset_no_write: out_we pulses %0d required 0", n_we - we0);
        end
        isNewWtin = 1'b1;
        step(2);
        isNewDin = 1'b1;
        wait_we("midreset_wait", ok);
        step(1);
`ifdef ACC_SEQ_PERF_CNT_EN
        exp_perf = 7;
`else
        exp_perf = 0;
`endif
        n_tests++;
        if (perf_busy_cycles !== 16'(exp_perf)) begin
            n_fail++;
            $display("FAIL perf_busy: got %0d required %0d", perf_busy_cycles, exp_perf);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_no_weights();
        test_both_same_cycle();
        test_wrap();
        test_overrun();
        test_reset_mid_pass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_compute_sequencer.md
Name: acc_compute_sequencer

Overview:
- Sequences the DNN array compute pass between the UART command controller and the output buffer.
- Detects the toggle-style "new input" and "new weights" strobes from the command controller.
- Issues a weight-latch pulse or an input-issue pulse to the MAC array, waits the array pipeline latency, then writes the result row into the output buffer at an auto-incrementing address.
- Reports busy, fill level and error status back to the controller.

Parameters:
- M, 16, output buffer depth (rows); addresses wrap modulo M.
- PIPE_LAT, 4, array latency in cycles from in_valid to result valid; legal range 1..255.
- ADDR_W, $clog2(M), output buffer address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- isNewDin  in  1  toggles once per completed input-vector load.
- isNewWtin  in  1  toggles once per completed weight-set load.
- wt_load  out  1  one-cycle pulse: array latches weight bus.
- in_valid  out  1  one-cycle pulse: array samples input vector.
- out_we  out  1  one-cycle output buffer write enable.
- out_addr  out  ADDR_W  output buffer write address.
- busy  out  1  high whenever state != IDLE.
- row_count  out  ADDR_W+1  rows written since reset, saturating at M.
- err_no_wt  out  1  sticky: input arrived before any weight load.
- err_overrun  out  1  sticky: input toggle lost because an input was already pending.
- perf_busy_cycles  out  16  busy-cycle counter (see Optional Feature).

Behaviour:
- Reset (synchronous):
  - State = IDLE.
  - All outputs 0; out_addr = 0; row_count = 0.
  - Toggle history registers = 0, matching the controller's toggle reset.
  - Pending flags cleared; wt_valid cleared.
  - Reset mid-pass aborts the pass with no out_we.
- Toggle detection:
  - Each clock, compare isNewDin and isNewWtin against their history registers.
  - On a difference: update the history register and set the matching pending flag (pend_in or pend_wt).
  - Detection runs in every state.
- Overrun: if a new input toggle is detected while pend_in is already set, set err_overrun; the flag stays 1 and the extra toggle is lost.
- States: IDLE, LOAD_WT, ISSUE, WAIT, WRITE.
- IDLE:
  - If pend_wt (including one set this cycle): go to LOAD_WT.
  - Else if pend_in and wt_valid: go to ISSUE.
  - Else if pend_in and !wt_valid: clear pend_in, set err_no_wt, stay in IDLE.
  - Weights take priority when both flags are pending.
- LOAD_WT:
  - wt_load = 1 for exactly this cycle.
  - Clear pend_wt; set wt_valid = 1; go to IDLE.
- ISSUE:
  - in_valid = 1 for exactly this cycle.
  - Clear pend_in; load wait counter = PIPE_LAT; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - Go to WRITE after PIPE_LAT cycles in WAIT.
  - Net timing: out_we rises exactly PIPE_LAT+1 cycles after in_valid.
- WRITE:
  - out_we = 1 with the current out_addr.
  - At the following clock edge: out_addr = (out_addr+1) mod M, and row_count increments, saturating at M.
  - Go to IDLE.
- Wrap: after address M-1 the next write goes to address 0 and overwrites it; row_count holds at M.
- Back-to-back passes: one IDLE cycle separates consecutive passes.
  - Input detected in IDLE → in_valid the next cycle.
  - Minimum spacing between in_valid pulses is PIPE_LAT+3 cycles.
- Weight toggle arriving during ISSUE/WAIT/WRITE stays pending and is serviced after WRITE. The in-flight pass completes with the old weights.

Optional Feature:
- Macro: ACC_SEQ_PERF_CNT_EN.
- Defined:
  - perf_busy_cycles increments on every cycle with busy=1, saturating at 16'hFFFF.
  - Reset clears it to 0.
- Undefined: no counter logic; perf_busy_cycles is tied to 16'h0000.

Test Plan:
- Weight toggle, then input toggle 10 cycles later (PIPE_LAT=4) → one wt_load pulse; one in_valid pulse; out_we exactly 5 cycles after in_valid with out_addr=0; then out_addr=1, row_count=1.
- Input toggle with no prior weight load → no in_valid, err_no_wt=1, busy stays 0.
- Both toggles in the same cycle → wt_load first, in_valid on the 3rd cycle after detection.
- Weights loaded, then 17 input passes with M=16 → addresses 0..15 then 0; row_count saturates at 16.
- Two input toggles during one pass's WAIT → second sets err_overrun=1; exactly two passes complete in total.
- Reset asserted during WAIT → no out_we, outputs 0; with ACC_SEQ_PERF_CNT_EN, perf_busy_cycles=0 after reset and equals the busy-cycle count of the next pass (7 for PIPE_LAT=4: ISSUE, 4×WAIT, WRITE, plus the LOAD_WT cycle if weights are reloaded).
